// File: rtl/fir_par2_prog.sv
// Programmable 2-parallel fast FIR built from three half-length sub-filters (H0, H1, H0+H1) with double-buffered taps.
// Build option FIR_PAR_SAT_EN: the output saturates and a sat_flag port is added; by default the output wraps.
module fir_par2_prog #(
    parameter int NUM_TAPS = 102,
    parameter int DATA_W   = 16,
    parameter int COEF_W   = 32,
    parameter int OUT_W    = 32,
    parameter int SHIFT    = 31,
    localparam int HT      = NUM_TAPS / 2,
    localparam int ACC_W   = DATA_W + COEF_W + 2 + $clog2(NUM_TAPS / 2),
    localparam int AW      = $clog2(NUM_TAPS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_even,
    input  logic signed [DATA_W-1:0] in_odd,
    input  logic                     cfg_we,
    input  logic [AW-1:0]            cfg_addr,
    input  logic signed [COEF_W-1:0] cfg_data,
    input  logic                     cfg_commit,
    output logic                     out_valid,
    output logic signed [OUT_W-1:0]  out_even,
    output logic signed [OUT_W-1:0]  out_odd
`ifdef FIR_PAR_SAT_EN
    ,
    output logic                     sat_flag
`endif
);

`ifdef FIR_PAR_SAT_EN
    localparam int RED_W = OUT_W + 1;
    localparam int EXT_W = (ACC_W > OUT_W) ? ACC_W : OUT_W + 1;
`else
    localparam int RED_W = OUT_W;
`endif

    // Shift right, then fit to OUT_W; with saturation the extra MSB reports a clip.
    function automatic logic [RED_W-1:0] reduce_out(input logic signed [ACC_W-1:0] v);
`ifdef FIR_PAR_SAT_EN
        logic signed [EXT_W-1:0] ext;
        logic signed [EXT_W-1:0] max_v;
        logic signed [EXT_W-1:0] min_v;
        ext   = EXT_W'(v >>> SHIFT);
        max_v = EXT_W'({1'b0, {(OUT_W-1){1'b1}}});
        min_v = -max_v - EXT_W'(1);
        if (ext > max_v) begin
            reduce_out = {1'b1, max_v[OUT_W-1:0]};
        end else if (ext < min_v) begin
            reduce_out = {1'b1, min_v[OUT_W-1:0]};
        end else begin
            reduce_out = {1'b0, ext[OUT_W-1:0]};
        end
`else
        reduce_out = OUT_W'(v >>> SHIFT);
`endif
    endfunction

    logic signed [COEF_W-1:0] shadow_q [NUM_TAPS];
    logic signed [COEF_W-1:0] shadow_d [NUM_TAPS];
    logic signed [COEF_W-1:0] active_q [NUM_TAPS];
    logic signed [COEF_W-1:0] active_d [NUM_TAPS];
    logic signed [DATA_W-1:0] xe_dl_q [HT];
    logic signed [DATA_W-1:0] xe_dl_d [HT];
    logic signed [DATA_W-1:0] xo_dl_q [HT];
    logic signed [DATA_W-1:0] xo_dl_d [HT];

    logic                    vld_p0_q, vld_p0_d;
    logic                    vld_p1_q, vld_p1_d;
    logic signed [ACC_W-1:0] a_p1_q, a_p1_d;
    logic signed [ACC_W-1:0] b_p1_q, b_p1_d;
    logic signed [ACC_W-1:0] c_p1_q, c_p1_d;
    logic signed [ACC_W-1:0] b_prev_q, b_prev_d;
    logic                    vld_p2_q, vld_p2_d;
    logic signed [OUT_W-1:0] y_even_p2_q, y_even_p2_d;
    logic signed [OUT_W-1:0] y_odd_p2_q, y_odd_p2_d;
`ifdef FIR_PAR_SAT_EN
    logic                    sat_p2_q, sat_p2_d;
`endif

    logic                    accept;
    logic signed [ACC_W-1:0] he, ho, xe, xo;
    logic signed [ACC_W-1:0] a_sum, b_sum, c_sum;
    logic signed [ACC_W-1:0] y_even, y_odd;
    logic [RED_W-1:0]        red_even, red_odd;

    assign accept = in_valid & ~clr;

    // Shadow takes writes; commit copies the pre-write shadow into the active bank.
    always_comb begin
        shadow_d = shadow_q;
        if (cfg_we && ({1'b0, cfg_addr} < (AW+1)'(NUM_TAPS))) begin
            shadow_d[cfg_addr] = cfg_data;
        end
        if (cfg_commit) begin
            active_d = shadow_q;
        end else begin
            active_d = active_q;
        end
    end

    // Stage 0: delay lines shift only on accepted pairs; clr empties them.
    always_comb begin
        xe_dl_d = xe_dl_q;
        xo_dl_d = xo_dl_q;
        if (clr) begin
            for (int k = 0; k < HT; k++) begin
                xe_dl_d[k] = '0;
                xo_dl_d[k] = '0;
            end
        end else if (in_valid) begin
            xe_dl_d[0] = in_even;
            xo_dl_d[0] = in_odd;
            for (int k = 1; k < HT; k++) begin
                xe_dl_d[k] = xe_dl_q[k-1];
                xo_dl_d[k] = xo_dl_q[k-1];
            end
        end
        vld_p0_d = accept;
    end

    // Stage 1: the three sub-filter sums, all at full ACC_W precision.
    always_comb begin
        he    = '0;
        ho    = '0;
        xe    = '0;
        xo    = '0;
        a_sum = '0;
        b_sum = '0;
        c_sum = '0;
        for (int k = 0; k < HT; k++) begin
            he    = ACC_W'(active_q[2*k]);
            ho    = ACC_W'(active_q[2*k+1]);
            xe    = ACC_W'(xe_dl_q[k]);
            xo    = ACC_W'(xo_dl_q[k]);
            a_sum = a_sum + he * xe;
            b_sum = b_sum + ho * xo;
            c_sum = c_sum + (he + ho) * (xe + xo);
        end
        vld_p1_d = vld_p0_q & ~clr;
        a_p1_d   = vld_p0_q ? a_sum : a_p1_q;
        b_p1_d   = vld_p0_q ? b_sum : b_p1_q;
        c_p1_d   = vld_p0_q ? c_sum : c_p1_q;
    end

    // Stage 2: recombine with the previous block's H1 term; outputs hold between beats.
    always_comb begin
        y_even      = a_p1_q + b_prev_q;
        y_odd       = c_p1_q - a_p1_q - b_p1_q;
        red_even    = reduce_out(y_even);
        red_odd     = reduce_out(y_odd);
        vld_p2_d    = vld_p1_q;
        y_even_p2_d = vld_p1_q ? red_even[OUT_W-1:0] : y_even_p2_q;
        y_odd_p2_d  = vld_p1_q ? red_odd[OUT_W-1:0] : y_odd_p2_q;
        if (clr) begin
            b_prev_d = '0;
        end else if (vld_p1_q) begin
            b_prev_d = b_p1_q;
        end else begin
            b_prev_d = b_prev_q;
        end
`ifdef FIR_PAR_SAT_EN
        sat_p2_d = vld_p1_q & (red_even[OUT_W] | red_odd[OUT_W]);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q    <= '{default: '0};
            active_q    <= '{default: '0};
            xe_dl_q     <= '{default: '0};
            xo_dl_q     <= '{default: '0};
            vld_p0_q    <= 1'b0;
            vld_p1_q    <= 1'b0;
            a_p1_q      <= '0;
            b_p1_q      <= '0;
            c_p1_q      <= '0;
            b_prev_q    <= '0;
            vld_p2_q    <= 1'b0;
            y_even_p2_q <= '0;
            y_odd_p2_q  <= '0;
`ifdef FIR_PAR_SAT_EN
            sat_p2_q    <= 1'b0;
`endif
        end else begin
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            xe_dl_q     <= xe_dl_d;
            xo_dl_q     <= xo_dl_d;
            vld_p0_q    <= vld_p0_d;
            vld_p1_q    <= vld_p1_d;
            a_p1_q      <= a_p1_d;
            b_p1_q      <= b_p1_d;
            c_p1_q      <= c_p1_d;
            b_prev_q    <= b_prev_d;
            vld_p2_q    <= vld_p2_d;
            y_even_p2_q <= y_even_p2_d;
            y_odd_p2_q  <= y_odd_p2_d;
`ifdef FIR_PAR_SAT_EN
            sat_p2_q    <= sat_p2_d;
`endif
        end
    end

    assign out_valid = vld_p2_q;
    assign out_even  = y_even_p2_q;
    assign out_odd   = y_odd_p2_q;
`ifdef FIR_PAR_SAT_EN
    assign sat_flag  = sat_p2_q;
`endif

endmodule
